// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Contents: slot and conversion-state enums, active-low cathode patterns, and
// small helpers mapping a scan slot to its cathode pattern and successor.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    SLOT_HUND,
    SLOT_TENS,
    SLOT_ONES
  } slot_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam logic [3:0] CATH_OFF  = 4'b1111;
  localparam logic [3:0] CATH_HUND = 4'b1011;
  localparam logic [3:0] CATH_TENS = 4'b1101;
  localparam logic [3:0] CATH_ONES = 4'b1110;

  function automatic logic [3:0] slot_cathode(input slot_t s);
    case (s)
      SLOT_HUND: slot_cathode = CATH_HUND;
      SLOT_TENS: slot_cathode = CATH_TENS;
      SLOT_ONES: slot_cathode = CATH_ONES;
      default:   slot_cathode = CATH_OFF;
    endcase
  endfunction

  function automatic slot_t next_slot(input slot_t s);
    case (s)
      SLOT_HUND: next_slot = SLOT_TENS;
      SLOT_TENS: next_slot = SLOT_ONES;
      default:   next_slot = SLOT_HUND;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_dabble_seq.sv
// Sequential double-dabble binary to 3-digit BCD converter.
// Ports: clk, reset (sync, active-high)
//        start - accepted only in IDLE; latches bin
//        bin   - binary operand (WIDTH bits)
//        busy  - high in SHIFT and DONE (registered)
//        done  - one-cycle pulse in DONE; bcd is valid in that cycle
//        bcd   - 12-bit BCD result {hundreds, tens, ones}
module dabble_seq
  import seg_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  conv_state_t         state_q, state_d;
  logic [WIDTH+11:0]   sr_q, sr_d, adj;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    // BCD field sits above the binary field; correct each nibble before shifting.
    adj     = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (adj[WIDTH+4*i +: 4] >= 4'd5) begin
        adj[WIDTH+4*i +: 4] = adj[WIDTH+4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {12'd0, bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = adj << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = sr_q[WIDTH +: 12];

endmodule

// File: rtl/seven_seg.sv
// BCD to 7-segment encoder (combinational), active-high segments.
// Ports: bcd  - BCD nibble in (values above 9 blank the display)
//        seg  - segments {g,f,e,d,c,b,a}, 1 = lit
module seven_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3f;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5b;
      4'd3:    seg = 7'h4f;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6d;
      4'd6:    seg = 7'h7d;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7f;
      4'd9:    seg = 7'h6f;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 3-digit multiplexed 7-segment display controller.
// Loads a binary value, converts it to BCD, and scans hundreds/tens/ones onto a
// shared segment bus with a blank (dead) time at the start of every digit slot.
// Optional build macro: LEADING_ZERO_SUPPRESS_EN blanks leading-zero hundreds/tens.
// Ports: clk, reset (sync, active-high)
//        value[WIDTH-1:0], load  - operand and one-cycle capture strobe
//        busy                    - conversion in progress
//        digit[3:0]              - BCD nibble of the current slot
//        segments[6:0]           - seven_seg encoding of digit
//        cathode[3:0]            - active-low digit select (bit 3 always 1)
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned PRESCALE     = 12000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned WIDTH        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic [3:0]       digit,
  output logic [6:0]       segments,
  output logic [3:0]       cathode
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic             eng_busy, eng_done, conv_start;
  logic [11:0]      eng_bcd;
  logic [WIDTH-1:0] conv_bin;

  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [11:0]      shadow_q, shadow_d;
  logic [11:0]      active_q, active_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  slot_t            slot_q, slot_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       cathode_q, cathode_d;
  logic [6:0]       seg_q, seg_enc;
  logic [3:0]       seg_in, nib;
  logic             frame_start, suppress;

  // Load / pending arbitration: a load wins over a pending value when idle.
  always_comb begin
    conv_start   = !eng_busy && (load || pend_valid_q);
    conv_bin     = load ? value : pend_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (eng_busy) begin
      if (load) begin
        pend_d       = value;
        pend_valid_d = 1'b1;
      end
    end else begin
      pend_valid_d = 1'b0;
    end
    shadow_d = eng_done ? eng_bcd : shadow_q;
  end

  dabble_seq #(
    .WIDTH(WIDTH)
  ) u_dabble (
    .clk  (clk),
    .reset(reset),
    .start(conv_start),
    .bin  (conv_bin),
    .busy (eng_busy),
    .done (eng_done),
    .bcd  (eng_bcd)
  );

  // Outputs are computed from the next scan position so they line up with it.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    slot_d = slot_q;
    if (cnt_q == CntW'(PRESCALE - 1)) begin
      cnt_d  = '0;
      slot_d = next_slot(slot_q);
    end
    frame_start = (cnt_d == '0) && (slot_d == SLOT_HUND);
    // Shadow is sampled before this cycle's write, so a coincident write waits a frame.
    active_d = frame_start ? shadow_q : active_q;
    case (slot_d)
      SLOT_HUND: nib = active_d[11:8];
      SLOT_TENS: nib = active_d[7:4];
      default:   nib = active_d[3:0];
    endcase
    // Bus changes only on entry to the blank phase.
    digit_d = (cnt_d == '0) ? nib : digit_q;
`ifdef LEADING_ZERO_SUPPRESS_EN
    suppress = ((slot_d == SLOT_HUND) && (active_d[11:8] == 4'd0)) ||
               ((slot_d == SLOT_TENS) && (active_d[11:8] == 4'd0) && (active_d[7:4] == 4'd0));
`else
    suppress = 1'b0;
`endif
    cathode_d = ((cnt_d < CntW'(BLANK_CYCLES)) || suppress) ? CATH_OFF : slot_cathode(slot_d);
    seg_in    = reset ? 4'd0 : digit_d;
  end

  seven_seg u_seg (
    .bcd(seg_in),
    .seg(seg_enc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      cnt_q        <= '0;
      slot_q       <= SLOT_HUND;
      digit_q      <= 4'd0;
      cathode_q    <= CATH_OFF;
      seg_q        <= seg_enc;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      digit_q      <= digit_d;
      cathode_q    <= cathode_d;
      seg_q        <= seg_enc;
    end
  end

  assign busy     = eng_busy;
  assign digit    = digit_q;
  assign segments = seg_q;
  assign cathode  = cathode_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (PRESCALE=8, BLANK_CYCLES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = 8'd0;
  logic       load = 1'b0;
  logic       busy;
  logic [3:0] digit;
  logic [6:0] segments;
  logic [3:0] cathode;

  int checks = 0;
  int failures = 0;
  int scan_k = 0;  // cycles since scan restart; frame = 24 cycles

  seg_scan_ctrl #(
    .PRESCALE    (8),
    .BLANK_CYCLES(2),
    .WIDTH       (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .load    (load),
    .busy    (busy),
    .digit   (digit),
    .segments(segments),
    .cathode (cathode)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
    return (d < 4'd10) ? tbl[d] : 7'h00;
  endfunction

  function automatic logic [3:0] cath_of(input int slot);
    case (slot)
      0:       return 4'b1011;
      1:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    scan_k++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    scan_k = 0;
  endtask

  task automatic go_to(input int k);
    while (scan_k < k) tick();
  endtask

  task automatic pulse_load(input logic [7:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Waits for the next frame start and checks every cycle of that frame.
  task automatic observe_frame(input string name, input logic [3:0] h, input logic [3:0] t,
                               input logic [3:0] o, input logic hoff, input logic toff);
    logic [3:0] dig [3];
    logic       off [3];
    logic [3:0] exp_c;
    dig = '{h, t, o};
    off = '{hoff, toff, 1'b0};
    while (scan_k % 24 != 0) tick();
    for (int c = 0; c < 24; c++) begin
      exp_c = ((c % 8) < 2 || off[c / 8]) ? 4'b1111 : cath_of(c / 8);
      checks++;
      if (cathode !== exp_c) begin
        failures++;
        $display("FAIL %s cathode@%0d: got %b expected %b", name, c, cathode, exp_c);
      end
      checks++;
      if (digit !== dig[c / 8]) begin
        failures++;
        $display("FAIL %s digit@%0d: got %0d expected %0d", name, c, digit, dig[c / 8]);
      end
      checks++;
      if (segments !== seg_of(dig[c / 8])) begin
        failures++;
        $display("FAIL %s segments@%0d: got %h expected %h", name, c, segments,
                 seg_of(dig[c / 8]));
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_c;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      exp_c = ((k % 8) < 2) ? 4'b1111 : cath_of((k / 8) % 3);
      checks++;
      if (cathode !== exp_c) begin
        failures++;
        $display("FAIL reset_scan cathode@%0d: got %b expected %b", k, cathode, exp_c);
      end
      checks++;
      if (digit !== 4'd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle@%0d: got digit=%0d busy=%b expected digit=0 busy=0",
                 k, digit, busy);
      end
      tick();
    end
  endtask

  task automatic test_load_255();
    do_reset();
    pulse_load(8'd255);
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (busy !== (i <= 9)) begin
        failures++;
        $display("FAIL load255 busy@%0d: got %b expected %b", i, busy, (i <= 9));
      end
      if (i < 10) tick();
    end
    checks++;
    if (digit !== 4'd0 || cathode !== 4'b1101) begin
      failures++;
      $display("FAIL load255 old_frame: got digit=%0d cath=%b expected digit=0 cath=1101",
               digit, cathode);
    end
    observe_frame("load255", 4'd2, 4'd5, 4'd5, 1'b0, 1'b0);
  endtask

  task automatic test_pending();
    do_reset();
    go_to(12);
    pulse_load(8'd12);
    go_to(15);
    pulse_load(8'd200);
    pulse_load(8'd7);
    go_to(21);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL pending busy_done: got %b expected 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL pending busy_idle_gap: got %b expected 0", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL pending busy_restart: got %b expected 1", busy);
    end
    observe_frame("pending_012", 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);
    observe_frame("pending_007", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    go_to(5);
    pulse_load(8'd99);
    go_to(9);
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || cathode !== 4'b1111 || digit !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid state: got busy=%b cath=%b digit=%0d expected 0 1111 0",
               busy, cathode, digit);
    end
    reset  = 1'b0;
    scan_k = 0;
    tick();
    checks++;
    if (cathode !== 4'b1111) begin
      failures++;
      $display("FAIL reset_mid blank1: got %b expected 1111", cathode);
    end
    tick();
    checks++;
    if (cathode !== 4'b1011) begin
      failures++;
      $display("FAIL reset_mid hund_active: got %b expected 1011", cathode);
    end
    observe_frame("reset_mid_cleared", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    pulse_load(8'd99);
    observe_frame("reset_mid_099", 4'd0, 4'd9, 4'd9, 1'b0, 1'b0);
  endtask

  task automatic test_tear_free();
    do_reset();
    pulse_load(8'd123);
    go_to(24);
    pulse_load(8'd45);
    go_to(26);
    checks++;
    if (digit !== 4'd1 || cathode !== 4'b1011) begin
      failures++;
      $display("FAIL tear hund_old: got digit=%0d cath=%b expected 1 1011", digit, cathode);
    end
    go_to(34);
    checks++;
    if (digit !== 4'd2 || cathode !== 4'b1101) begin
      failures++;
      $display("FAIL tear tens_old: got digit=%0d cath=%b expected 2 1101", digit, cathode);
    end
    go_to(42);
    checks++;
    if (digit !== 4'd3 || cathode !== 4'b1110) begin
      failures++;
      $display("FAIL tear ones_old: got digit=%0d cath=%b expected 3 1110", digit, cathode);
    end
    observe_frame("tear_new", 4'd0, 4'd4, 4'd5, 1'b0, 1'b0);
  endtask

  task automatic test_leading_zero();
    logic lzs;
`ifdef LEADING_ZERO_SUPPRESS_EN
    lzs = 1'b1;
`else
    lzs = 1'b0;
`endif
    do_reset();
    pulse_load(8'd5);
    observe_frame("lz_005", 4'd0, 4'd0, 4'd5, lzs, lzs);
    pulse_load(8'd100);
    observe_frame("lz_100", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    pulse_load(8'd50);
    observe_frame("lz_050", 4'd0, 4'd5, 4'd0, lzs, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_255();
    test_pending();
    test_reset_mid();
    test_tear_free();
    test_leading_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Display controller for the 3-digit multiplexed 7-segment panel driven by the CPU's 8-bit output.
- Converts each loaded binary value to BCD with a sequential double-dabble engine.
- Holds the result in tear-free shadow/active registers.
- Time-multiplexes the hundreds, tens and ones digits onto the shared segment bus, with a programmable dead time between digits to prevent ghosting.
- Replaces the free-running combinational scan in the board top level.

Parameters:
PRESCALE, 12000, clk cycles per digit slot (dead time included); must be > BLANK_CYCLES.
BLANK_CYCLES, 64, cycles at the start of each slot with all cathodes off; must be >= 1.
WIDTH, 8, binary input width; BCD output is fixed at 3 digits (12 bits).

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
value  in  WIDTH  binary value to display.
load  in  1  one-cycle strobe; captures value.
busy  out  1  high while a conversion is in progress.
digit  out  4  BCD nibble of the slot currently being driven.
segments  out  7  encoded segments for digit, produced by an internal seven_seg instance (same polarity as seven_seg).
cathode  out  4  active-low digit select: 1011 hundreds, 1101 tens, 1110 ones, 1111 off. Bit 3 is constant 1.

Behaviour:
- Reset (synchronous, active-high; applies mid-conversion or mid-slot):
  - cathode=4'b1111, digit=0, busy=0.
  - pending, shadow and active registers cleared to 0; pending-valid flag cleared.
  - Conversion FSM goes to IDLE; scan restarts at the hundreds slot, blank phase, slot counter 0.
- Conversion FSM (IDLE -> SHIFT -> DONE -> IDLE):
  - IDLE: if load is high, or pending-valid is set, latch the operand and go to SHIFT. A load has priority over the pending value in the same cycle, and that pending value is discarded.
  - SHIFT: exactly WIDTH cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left by 1.
  - DONE: one cycle; write the 12-bit BCD to shadow, then return to IDLE.
  - busy is high in SHIFT and DONE: it rises the cycle after load and stays high for WIDTH+1 cycles.
  - Example: load at cycle 0 -> shadow updated at the end of cycle WIDTH+1 -> next conversion can start at cycle WIDTH+2.
- Load while busy:
  - value goes into a one-deep pending register and pending-valid is set.
  - A later load while still busy overwrites pending (last value wins).
  - pending is consumed on the return to IDLE.
- Max input 255 -> BCD 0x255. No overflow is possible for WIDTH <= 9.
- Scan:
  - Slot counter runs 0..PRESCALE-1, then wraps.
  - Slot order: hundreds -> tens -> ones -> hundreds.
  - Counter values 0..BLANK_CYCLES-1: cathode=1111.
  - Remaining counter values: cathode selects the slot's digit; digit and segments show that nibble from the active register.
  - digit and segments are updated at the start of the blank phase, so the bus is stable before the cathode enables.
- Tear-free update:
  - active <= shadow only on the first cycle of a hundreds slot (frame start).
  - A shadow write on the same cycle as a frame start is not seen until the next frame.
- All outputs are registered.

Optional Feature:
LEADING_ZERO_SUPPRESS_EN
- Defined:
  - Hundreds slot keeps cathode=1111 for the whole slot if hundreds==0.
  - Tens slot keeps cathode=1111 if hundreds==0 and tens==0.
  - Ones digit is always shown.
  - Slot timing is unchanged (blanked slots still take PRESCALE cycles).
- Undefined: every digit is shown, including leading zeros (value 5 displays 005).

Decomposition:
- Package seg_scan_pkg:
  - slot_t enum: SLOT_HUND, SLOT_TENS, SLOT_ONES.
  - conv_state_t enum: IDLE, SHIFT, DONE.
  - Cathode constants: CATH_OFF=4'b1111, CATH_HUND=4'b1011, CATH_TENS=4'b1101, CATH_ONES=4'b1110.
- Sub-module dabble_seq: the sequential double-dabble engine.
  - Ports: clk, reset, start, bin, busy, done, bcd.
- Instantiates the existing seven_seg encoder unchanged.

Test Plan:
All scenarios use PRESCALE=8, BLANK_CYCLES=2.
- Reset then idle -> cathode=1111 for 2 cycles, 1011 for 6, 1111 for 2, 1101 for 6, 1111 for 2, 1110 for 6, repeating; digit=0 throughout; busy=0.
- load value=255 at cycle 0 -> busy high cycles 1..9, shadow=0x255 after cycle 9; after the next frame start, digit=2,5,5 in the hundreds, tens and ones active phases.
- load 12, then load 200 three cycles later, then load 7 one cycle after that -> shadow goes to 0x012, then 0x007; 200 never appears in shadow or on digit.
- reset asserted at cycle 4 of a conversion of 99 -> busy=0 next cycle, shadow stays 0, scan restarts at hundreds blank; a subsequent load of 99 completes normally to 0x099.
- Shadow written mid-frame, during the tens slot -> tens and ones slots of the current frame still show the old digits; the new digits appear from the next hundreds slot.
- LEADING_ZERO_SUPPRESS_EN defined: value 5 -> hundreds and tens slots fully 1111, ones shows 5; value 100 -> 1,0,0 all shown. Undefined: value 5 -> 0,0,5.
